opc2_uart: RTL and testbench



---
 rtl/opc2_pkg.sv | 16 +
 rtl/opc2_uart_if.sv | 8 +
 rtl/opc2_uart_fifo.sv | 40 ++++
 rtl/opc2_uart.sv | 241 ++++++++++++++++++++++++
 tb/tb_opc2_uart.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/opc2_pkg.sv
// Shared definitions for the opc2 serial port: register offsets, STATUS bit positions
// and the state type used by both the transmit and receive sequencers.
package opc2_pkg;

  localparam logic [10:0] REG_STATUS = 11'd0;
  localparam logic [10:0] REG_DATA   = 11'd1;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_VALID   = 2;
  localparam int unsigned ST_RX_OVERRUN = 3;
  localparam int unsigned ST_TX_BUSY    = 4;

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} uart_state_t;

endpackage

// File: rtl/opc2_uart_if.sv
// CPU-side address/strobe group of the opc2 bus; the tristate data lines stay a plain port.
interface opc2_uart_if;
  logic [10:0] address;
  logic        rnw;

  modport master (output address, output rnw);
  modport slave  (input address, input rnw);
endinterface

// File: rtl/opc2_uart_fifo.sv
// Byte FIFO feeding the transmitter. Storage is not reset; only the pointers are.
module opc2_uart_fifo #(
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  // Extra MSB on each pointer distinguishes full from empty.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/opc2_uart.sv
// Memory-mapped 8N1 serial port for the opc2 CPU: STATUS/DATA decode, TX FIFO + shifter,
// and a single-byte receive holding register.
module opc2_uart
  import opc2_pkg::*;
#(
  parameter logic [10:0] BASE_ADDR = 11'h7FE,
  parameter logic [15:0] CLK_DIV   = 16'd868,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  opc2_uart_if.slave       bus,
  inout  wire        [7:0] data,
  input  logic             rxd,
  output logic             txd
);

  localparam logic [15:0] BitLast    = CLK_DIV - 16'd1;
  localparam logic [15:0] RxHalfLast = (CLK_DIV >> 1) - 16'd1;

  logic       sel_status, sel_data, rd_en, rd_data, wr_status, wr_data;
  logic [7:0] status, rd_value;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_hold_q, rx_hold_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, rx_done;

  // Bus decode
  assign sel_status = (bus.address == BASE_ADDR + REG_STATUS);
  assign sel_data   = (bus.address == BASE_ADDR + REG_DATA);
  assign rd_en      = bus.rnw && (sel_status || sel_data);
  assign rd_data    = bus.rnw && sel_data;
  assign wr_status  = !bus.rnw && sel_status;
  assign wr_data    = !bus.rnw && sel_data;

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_EMPTY]   = fifo_empty;
    status[ST_RX_VALID]   = rx_valid_q;
    status[ST_RX_OVERRUN] = rx_overrun_q;
    status[ST_TX_BUSY]    = (tx_state_q != IDLE);
  end

  assign rd_value = sel_status ? status : rx_hold_q;
  assign data     = rd_en ? rd_value : 8'bz;

  // A full FIFO still accepts a byte when the transmitter pops on the same edge.
  assign fifo_push = wr_data && (!fifo_full || fifo_pop);

  opc2_uart_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Transmitter
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_state_d = START;
          tx_shift_d = fifo_dout;
          tx_div_d   = '0;
          fifo_pop   = 1'b1;
        end
      end
      START: begin
        if (tx_div_q == BitLast) begin
          tx_state_d = BITS;
          tx_div_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_div_d = tx_div_q + 16'd1;
        end
      end
      BITS: begin
        if (tx_div_q == BitLast) begin
          tx_div_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
        end else begin
          tx_div_d = tx_div_q + 16'd1;
        end
      end
      STOP: begin
        if (tx_div_q == BitLast) begin
          tx_div_d = '0;
          if (!fifo_empty) begin
            tx_state_d = START;
            tx_shift_d = fifo_dout;
            fifo_pop   = 1'b1;
          end else begin
            tx_state_d = IDLE;
          end
        end else begin
          tx_div_d = tx_div_q + 16'd1;
        end
      end
      default: tx_state_d = IDLE;
    endcase

    // Line level follows the next state so txd is a clean flop output.
    case (tx_state_d)
      START:   txd_d = 1'b0;
      BITS:    txd_d = tx_shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_state_q <= IDLE;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd = txd_q;

  // Receiver
  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = START;
          rx_div_d   = '0;
        end
      end
      START: begin
        if (rx_div_q == RxHalfLast) begin
          rx_div_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : BITS;
        end else begin
          rx_div_d = rx_div_q + 16'd1;
        end
      end
      BITS: begin
        if (rx_div_q == BitLast) begin
          rx_div_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end else begin
          rx_div_d = rx_div_q + 16'd1;
        end
      end
      STOP: begin
        if (rx_div_q == BitLast) begin
          rx_div_d   = '0;
          rx_state_d = IDLE;
          rx_done    = rx_s2_q;
        end else begin
          rx_div_d = rx_div_q + 16'd1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // A byte completing on the same edge as a DATA read wins and is not an overrun.
  always_comb begin
    rx_hold_d    = rx_hold_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    if (rd_data)   rx_valid_d   = 1'b0;
    if (wr_status) rx_overrun_d = 1'b0;
    if (rx_done) begin
      rx_hold_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_data) rx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= IDLE;
      rx_div_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_hold_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_s1_q      <= rxd;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_hold_q    <= rx_hold_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_opc2_uart.sv
// Scoreboard bench for opc2_uart: TX bytes are decoded off txd, RX bytes are read back
// over the bus, and STATUS is checked against a small model of the flags.
module tb_opc2_uart;

  localparam int          Div        = 4;
  localparam logic [10:0] StatusAddr = 11'h7FE;
  localparam logic [10:0] DataAddr   = 11'h7FF;
  localparam logic [10:0] IdleAddr   = 11'h100;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;
  wire  [7:0] data;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_wdata = '0;

  opc2_uart_if bus ();

  assign data = tb_oe ? tb_wdata : 8'bz;

  opc2_uart #(
    .BASE_ADDR (11'h7FE),
    .CLK_DIV   (16'd4),
    .TX_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus),
    .data    (data),
    .rxd     (rxd),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rst_count = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         tx_start[$];
  logic       exp_overrun = 1'b0;
  logic [7:0] rx_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [10:0] addr, output logic [7:0] val);
    @(negedge clk);
    bus.address = addr;
    bus.rnw     = 1'b1;
    tb_oe       = 1'b0;
    #1 val = data;
    @(posedge clk);
    #1 bus.address = IdleAddr;
  endtask

  task automatic bus_write(input logic [10:0] addr, input logic [7:0] val, output int wcyc);
    @(negedge clk);
    bus.address = addr;
    bus.rnw     = 1'b0;
    tb_wdata    = val;
    tb_oe       = 1'b1;
    @(posedge clk);
    #1 wcyc = cyc;
    bus.rnw     = 1'b1;
    tb_oe       = 1'b0;
    bus.address = IdleAddr;
  endtask

  task automatic tx_write(input logic [7:0] val, input bit accepted, output int wcyc);
    bus_write(DataAddr, val, wcyc);
    if (accepted) tx_q.push_back(val);
  endtask

  function automatic logic [7:0] rx_status();
    return {4'b0, exp_overrun, rx_q.size() != 0, 1'b1, 1'b0};
  endfunction

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    if (rx_q.size() != 0) exp_overrun = 1'b1;
    rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = fr[i];
      repeat (Div - 1) @(negedge clk);
    end
  endtask

  task automatic read_rx(input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    exp = (rx_q.size() != 0) ? rx_q[$] : rx_last;
    bus_read(DataAddr, got);
    check(tag, {24'b0, got}, {24'b0, exp});
    rx_last = exp;
    rx_q.delete();
  endtask

  task automatic wait_tx_idle();
    logic [7:0] st;
    bit         done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      bus_read(StatusAddr, st);
      if (!st[4] && st[1]) done = 1'b1;
    end
    check("tx_idle_wait", {31'b0, done}, 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_rx_valid();
    logic [7:0] st;
    bit         done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      bus_read(StatusAddr, st);
      if (st[2]) done = 1'b1;
    end
    check("rx_valid_wait", {31'b0, done}, 32'd1);
  endtask

  // Decodes each frame on txd at bit centres and pops the expected byte.
  initial begin : tx_mon
    int         start;
    int         rc;
    logic [9:0] bits;
    wait (reset_b);
    forever begin
      @(negedge txd);
      #1 start = cyc;
      rc = rst_count;
      repeat (Div / 2) @(posedge clk);
      #1 bits[0] = txd;
      for (int i = 1; i < 10; i++) begin
        repeat (Div) @(posedge clk);
        #1 bits[i] = txd;
      end
      if (rc == rst_count) begin
        check("tx_start_bit", {31'b0, bits[0]}, 32'd0);
        check("tx_stop_bit", {31'b0, bits[9]}, 32'd1);
        if (tx_q.size() == 0) check("tx_extra_frame", {24'b0, bits[8:1]}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'b0, bits[8:1]}, {24'b0, tx_q.pop_front()});
        tx_start.push_back(start);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] st;
    int         wc;
    int         first_wc;

    bus.address = IdleAddr;
    bus.rnw     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;

    // Reset state and bus release
    #1 check("reset_txd", {31'b0, txd}, 32'd1);
    bus_read(StatusAddr, st);
    check("reset_status", {24'b0, st}, 32'h02);
    @(negedge clk);
    tb_wdata = 8'hC3;
    tb_oe    = 1'b1;
    #1 check("bus_released", {24'b0, data}, 32'hC3);
    tb_oe = 1'b0;

    // Single byte A5
    tx_write(8'hA5, 1'b1, first_wc);
    bus_read(StatusAddr, st);
    check("status_queued", {24'b0, st}, 32'h00);
    bus_read(StatusAddr, st);
    check("status_busy", {24'b0, st}, 32'h12);
    wait_tx_idle();
    check("tx_a5_frames", tx_start.size(), 1);
    if (tx_start.size() != 0) check("tx_first_latency", tx_start[0] - first_wc, 1);
    tx_start.delete();

    // Back-to-back bytes filling the FIFO; the sixth is dropped
    tx_write(8'h01, 1'b1, first_wc);
    for (int i = 2; i <= 5; i++) tx_write(8'(i), 1'b1, wc);
    bus_read(StatusAddr, st);
    check("status_full", {24'b0, st}, 32'h11);
    tx_write(8'h06, 1'b0, wc);
    bus_read(StatusAddr, st);
    check("status_still_full", {24'b0, st}, 32'h11);
    wait_tx_idle();
    check("b2b_frames", tx_start.size(), 5);
    if (tx_start.size() == 5) begin
      check("b2b_first_latency", tx_start[0] - first_wc, 1);
      for (int i = 1; i < 5; i++) check("b2b_no_gap", tx_start[i] - tx_start[i-1], 10 * Div);
    end
    tx_start.delete();
    check("tx_queue_drained", tx_q.size(), 0);

    // Receive one byte
    send_rx(8'h3C);
    wait_rx_valid();
    bus_read(StatusAddr, st);
    check("rx_status_valid", {24'b0, st}, {24'b0, rx_status()});
    read_rx("rx_data_3c");
    bus_read(StatusAddr, st);
    check("rx_status_cleared", {24'b0, st}, {24'b0, rx_status()});

    // Overrun
    send_rx(8'h11);
    send_rx(8'h22);
    repeat (10) @(posedge clk);
    bus_read(StatusAddr, st);
    check("rx_status_overrun", {24'b0, st}, {24'b0, rx_status()});
    check("rx_overrun_is_0e", {24'b0, st}, 32'h0E);
    read_rx("rx_data_22");
    bus_read(StatusAddr, st);
    check("rx_overrun_sticky", {24'b0, st}, {24'b0, rx_status()});
    bus_write(StatusAddr, 8'h00, wc);
    exp_overrun = 1'b0;
    bus_read(StatusAddr, st);
    check("rx_overrun_clear", {24'b0, st}, {24'b0, rx_status()});

    // Short glitch is not a start bit
    @(negedge clk);
    rxd = 1'b0;
    repeat (Div / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    bus_read(StatusAddr, st);
    check("rx_glitch_ignored", {24'b0, st}, 32'h02);
    send_rx(8'h5A);
    wait_rx_valid();
    read_rx("rx_data_5a");
    read_rx("rx_data_reread");
    bus_read(StatusAddr, st);
    check("rx_reread_no_effect", {24'b0, st}, 32'h02);

    // Reset mid-frame
    tx_write(8'h77, 1'b1, wc);
    repeat (12) @(posedge clk);
    @(negedge clk);
    #2 reset_b = 1'b0;
    rst_count++;
    tx_q.delete();
    #1 check("rst_async_txd", {31'b0, txd}, 32'd1);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    bus_read(StatusAddr, st);
    check("rst_status", {24'b0, st}, 32'h02);
    repeat (50) @(posedge clk);
    check("rst_txd_idle", {31'b0, txd}, 32'd1);
    check("rst_no_frames", tx_start.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
